load_store_unit: RTL and testbench

//  Memory-access stage between execute and read_data_memory. Accepts one load/store per

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and data memory.
// Takes one load/store per request handshake, forms EA = base + sext(disp),
// holds the memory interface stable for MEM_LATENCY cycles, formats load data
// and returns one completion. Only one request is ever in flight.
//
// Handshake rule for both the req_* and resp_* channels: a transfer happens on
// the rising clock edge where valid and ready are both high. The producer keeps
// its payload stable while valid is high and ready is low. Here req_ready is
// high only in IDLE and resp_valid only in RESP, so neither channel ever sees
// a combinational path from its own valid to its own ready.
module load_store_unit #(
   parameter int MEM_DEPTH   = 256,
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_opcode,
   input  logic [63:0] req_base,
   input  logic [15:0] req_disp,
   input  logic [63:0] req_store_data,
   input  logic [4:0]  req_rt,
   output logic [63:0] mem_address,
   output logic [63:0] mem_write_data,
   output logic [5:0]  mem_opcode,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [63:0] mem_read_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic [4:0]  resp_rt,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   localparam logic [5:0] OP_LBZ = 6'd34;
   localparam logic [5:0] OP_LHZ = 6'd40;
   localparam logic [5:0] OP_LHA = 6'd42;
   localparam logic [5:0] OP_LWZ = 6'd32;
   localparam logic [5:0] OP_LD  = 6'd58;
   localparam logic [5:0] OP_STB = 6'd38;
   localparam logic [5:0] OP_STH = 6'd44;
   localparam logic [5:0] OP_STW = 6'd36;
   localparam logic [5:0] OP_STD = 6'd62;

   // Counter wide enough to hold MEM_LATENCY-1.
   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] lat_cnt;
   logic          acc_store;

   logic [63:0]   ea;
   logic          req_is_load;
   logic          req_is_store;
   logic          ea_in_range;
   logic          req_legal;
   logic          accept;

   // Zero/sign extension of the raw memory word by load opcode.
   function automatic logic [63:0] format_load(input logic [63:0] word,
                                                input logic [5:0]  op);
      logic [63:0] res;
      case (op)
         OP_LBZ:  res = {56'd0, word[7:0]};
         OP_LHZ:  res = {48'd0, word[15:0]};
         OP_LHA:  res = {{48{word[15]}}, word[15:0]};
         OP_LWZ:  res = {32'd0, word[31:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   // EA wraps modulo 2^64; the range check is unsigned, so a negative
   // displacement that wraps below zero lands far out of range.
   assign ea          = req_base + {{48{req_disp[15]}}, req_disp};
   assign ea_in_range = (ea < 64'(MEM_DEPTH));
   assign req_legal   = (req_is_load || req_is_store) && ea_in_range;
   assign accept      = req_valid && req_ready;
   assign dbg_state   = state;

   // Opcode classification of the incoming request.
   always_comb begin
      req_is_load  = 1'b0;
      req_is_store = 1'b0;
      case (req_opcode)
         OP_LBZ, OP_LHZ, OP_LHA, OP_LWZ, OP_LD: req_is_load  = 1'b1;
         OP_STB, OP_STH, OP_STW, OP_STD:        req_is_store = 1'b1;
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and state-decoded handshake/strobe outputs.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (accept) begin
               state_next = req_legal ? S_ACCESS : S_RESP;
            end
         end
         S_ACCESS: begin
            mem_read  = !acc_store;
            mem_write = acc_store;
            if (lat_cnt == '0) begin
               state_next = S_RESP;
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Request capture, latency countdown and load-data formatting. The memory
   // bus registers only change on a legal accept, so an error request leaves
   // mem_address untouched and the address-sensitive memory sees no change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_address    <= '0;
         mem_write_data <= '0;
         mem_opcode     <= '0;
         acc_store      <= 1'b0;
         lat_cnt        <= '0;
         resp_data      <= '0;
         resp_rt        <= '0;
         resp_err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  resp_rt   <= req_rt;
                  resp_data <= '0;
                  if (req_legal) begin
                     mem_address    <= ea;
                     mem_write_data <= req_store_data;
                     mem_opcode     <= req_opcode;
                     acc_store      <= req_is_store;
                     lat_cnt        <= CW'(MEM_LATENCY - 1);
                     resp_err       <= 1'b0;
                  end else begin
                     resp_err <= 1'b1;
                  end
               end
            end
            S_ACCESS: begin
               if (lat_cnt == '0) begin
                  resp_data <= acc_store ? 64'd0 : format_load(mem_read_data, mem_opcode);
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table, hand-written multi-cycle corner
// sequences and a short random run against a word-addressed memory model.
module tb_load_store_unit;

   localparam int LAT   = 3;
   localparam int DEPTH = 256;
   localparam int TMO   = 40;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_opcode;
   logic [63:0] req_base;
   logic [15:0] req_disp;
   logic [63:0] req_store_data;
   logic [4:0]  req_rt;
   logic [63:0] mem_address;
   logic [63:0] mem_write_data;
   logic [5:0]  mem_opcode;
   logic        mem_write;
   logic        mem_read;
   logic [63:0] mem_read_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic [4:0]  resp_rt;
   logic        resp_err;
   logic [1:0]  dbg_state;

   load_store_unit #(.MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_opcode     (req_opcode),
      .req_base       (req_base),
      .req_disp       (req_disp),
      .req_store_data (req_store_data),
      .req_rt         (req_rt),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_opcode     (mem_opcode),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_read_data  (mem_read_data),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_data      (resp_data),
      .resp_rt        (resp_rt),
      .resp_err       (resp_err),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- bookkeeping ----------------
   int checks   = 0;
   int failures = 0;
   int overlap  = 0;
   logic [69:0] exp_q[$];

   logic [63:0] mem     [0:DEPTH-1] = '{default: 64'd0};
   logic [63:0] ref_mem [0:DEPTH-1] = '{default: 64'd0};

   function automatic bit is_ld(input logic [5:0] op);
      return (op == 6'd34) || (op == 6'd40) || (op == 6'd42) || (op == 6'd32) || (op == 6'd58);
   endfunction

   function automatic bit is_st(input logic [5:0] op);
      return (op == 6'd38) || (op == 6'd44) || (op == 6'd36) || (op == 6'd62);
   endfunction

   function automatic logic [63:0] fmt(input logic [63:0] w, input logic [5:0] op);
      logic [63:0] r;
      case (op)
         6'd34:   r = {56'd0, w[7:0]};
         6'd40:   r = {48'd0, w[15:0]};
         6'd42:   r = {{48{w[15]}}, w[15:0]};
         6'd32:   r = {32'd0, w[31:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                         input logic [5:0] op);
      logic [63:0] r;
      case (op)
         6'd38:   r = {old[63:8], d[7:0]};
         6'd44:   r = {old[63:16], d[15:0]};
         6'd36:   r = {old[63:32], d[31:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- memory model ----------------
   always_comb begin
      mem_read_data = 64'd0;
      if (mem_address < 64'(DEPTH)) mem_read_data = mem[mem_address[7:0]];
   end

   always @(posedge clk) begin
      if (mem_write && (mem_address < 64'(DEPTH)))
         mem[mem_address[7:0]] <= merge(mem[mem_address[7:0]], mem_write_data, mem_opcode);
   end

   // ---------------- scoreboard ----------------
   // Samples 2 time units after the falling edge, after any bench drive at
   // that edge, so the handshake seen here is the one the next rising edge takes.
   always begin
      @(negedge clk);
      #2;
      if (mem_read && mem_write) overlap++;
      if (rst_n && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp actual=0x%0h expected=none",
                     {resp_err, resp_rt, resp_data});
         end else begin
            check("resp", {resp_err, resp_rt, resp_data}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [5:0] op, input logic [63:0] base, input logic [15:0] disp,
                        input logic [63:0] sd, input logic [4:0] rt);
      req_valid      = 1'b1;
      req_opcode     = op;
      req_base       = base;
      req_disp       = disp;
      req_store_data = sd;
      req_rt         = rt;
   endtask

   task automatic scramble_req();
      req_opcode     = 6'($urandom);
      req_base       = {$urandom, $urandom};
      req_disp       = 16'($urandom);
      req_store_data = {$urandom, $urandom};
      req_rt         = 5'($urandom);
   endtask

   // Full transaction with resp_ready high: latency, strobe count, bus
   // contents while strobed, address hold afterwards, and retirement.
   task automatic do_req(input string name, input logic [5:0] op, input logic [63:0] base,
                         input logic [15:0] disp, input logic [63:0] sd, input logic [4:0] rt,
                         input logic [63:0] exp_data, input logic exp_err);
      logic [63:0] ea;
      logic [63:0] addr_before;
      int waited;
      int lat;
      int strobes;
      int bad;
      bit legal;
      ea    = base + {{48{disp[15]}}, disp};
      legal = (is_ld(op) || is_st(op)) && (ea < 64'(DEPTH));
      waited = 0;
      while (!req_ready && waited < TMO) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $display("FAIL %s_ready_timeout actual=req_ready 0 expected=1", name);
         return;
      end
      addr_before = mem_address;
      drive(op, base, disp, sd, rt);
      exp_q.push_back({exp_err, rt, exp_data});
      @(negedge clk);
      req_valid = 1'b0;
      scramble_req();
      lat     = 1;
      strobes = 0;
      bad     = 0;
      while (!resp_valid && lat <= TMO) begin
         if (mem_read || mem_write) begin
            strobes++;
            if (mem_address !== ea || mem_write !== is_st(op) || mem_opcode !== op ||
                (is_st(op) && mem_write_data !== sd))
               bad++;
         end
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, 70'(lat), legal ? 70'(LAT + 1) : 70'd1);
      check({name, "_strobes"}, 70'(strobes), legal ? 70'(LAT) : 70'd0);
      check({name, "_strobe_bus"}, 70'(bad), 70'd0);
      check({name, "_addr_hold"}, 70'(mem_address), legal ? 70'(ea) : 70'(addr_before));
      if (legal && is_st(op)) ref_mem[ea[7:0]] = merge(ref_mem[ea[7:0]], sd, op);
      @(negedge clk);
      check({name, "_retired"}, {68'd0, resp_valid, req_ready}, 70'd1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [5:0]  op;
      logic [63:0] base;
      logic [15:0] disp;
      logic [63:0] sd;
      logic [4:0]  rt;
      logic [63:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [20];
   logic [5:0] ops [10] = '{6'd34, 6'd40, 6'd42, 6'd32, 6'd58, 6'd38, 6'd44, 6'd36, 6'd62, 6'd7};

   initial begin
      int bad;
      int seen;
      logic [63:0] d0;
      logic [63:0] ea;
      logic [5:0]  op;
      logic [63:0] base;
      logic [15:0] disp;
      logic [63:0] sd;
      logic        legal;

      vecs[0]  = '{6'd62, 64'h10, 16'd3, 64'hDEADBEEF_01234567, 5'd1, 64'h0, 1'b0};
      vecs[1]  = '{6'd34, 64'h10, 16'd3, 64'h0, 5'd2, 64'h67, 1'b0};
      vecs[2]  = '{6'd40, 64'h13, 16'd0, 64'h0, 5'd3, 64'h4567, 1'b0};
      vecs[3]  = '{6'd42, 64'h14, 16'hFFFF, 64'h0, 5'd4, 64'h4567, 1'b0};
      vecs[4]  = '{6'd32, 64'h13, 16'd0, 64'h0, 5'd5, 64'h0123_4567, 1'b0};
      vecs[5]  = '{6'd58, 64'h13, 16'd0, 64'h0, 5'd6, 64'hDEADBEEF_01234567, 1'b0};
      vecs[6]  = '{6'd44, 64'h20, 16'd0, 64'h1111_2222_3333_8001, 5'd7, 64'h0, 1'b0};
      vecs[7]  = '{6'd42, 64'h20, 16'd0, 64'h0, 5'd8, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
      vecs[8]  = '{6'd40, 64'h20, 16'd0, 64'h0, 5'd9, 64'h8001, 1'b0};
      vecs[9]  = '{6'd34, 64'h20, 16'd0, 64'h0, 5'd10, 64'h01, 1'b0};
      vecs[10] = '{6'd36, 64'hFF, 16'd0, 64'hAAAA_AAAA_8000_0000, 5'd11, 64'h0, 1'b0};
      vecs[11] = '{6'd32, 64'h100, 16'hFFFF, 64'h0, 5'd12, 64'h8000_0000, 1'b0};
      vecs[12] = '{6'd38, 64'hFFFF_FFFF_FFFF_FFF0, 16'h20, 64'h1234_5678_9ABC_DE5A, 5'd13, 64'h0, 1'b0};
      vecs[13] = '{6'd58, 64'h10, 16'd0, 64'h0, 5'd14, 64'h5A, 1'b0};
      vecs[14] = '{6'd58, 64'h100, 16'd0, 64'h0, 5'd15, 64'h0, 1'b1};
      vecs[15] = '{6'd34, 64'h5, 16'hFFFA, 64'h0, 5'd16, 64'h0, 1'b1};
      vecs[16] = '{6'd0, 64'h10, 16'd0, 64'h0, 5'd17, 64'h0, 1'b1};
      vecs[17] = '{6'd63, 64'h10, 16'd0, 64'h0, 5'd18, 64'h0, 1'b1};
      vecs[18] = '{6'd62, 64'h100, 16'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd19, 64'h0, 1'b1};
      vecs[19] = '{6'd58, 64'hFF, 16'd0, 64'h0, 5'd20, 64'h8000_0000, 1'b0};

      rst_n          = 1'b0;
      req_valid      = 1'b0;
      req_opcode     = '0;
      req_base       = '0;
      req_disp       = '0;
      req_store_data = '0;
      req_rt         = '0;
      resp_ready     = 1'b1;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("rst_ready_strobes_valid_err",
            {65'd0, req_ready, mem_read, mem_write, resp_valid, resp_err}, 70'h10);
      check("rst_mem_address", 70'(mem_address), 70'd0);
      check("rst_mem_write_data", 70'(mem_write_data), 70'd0);
      check("rst_mem_opcode", 70'(mem_opcode), 70'd0);
      check("rst_resp_data_rt", {1'b0, resp_rt, resp_data}, 70'd0);
      check("rst_state", 70'(dbg_state), 70'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- table ----
      for (int i = 0; i < 20; i++) begin
         do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].base, vecs[i].disp, vecs[i].sd,
                vecs[i].rt, vecs[i].exp_data, vecs[i].exp_err);
      end

      // ---- illegal opcode with the consumer stalled ----
      resp_ready = 1'b0;
      drive(6'd0, 64'h10, 16'd0, 64'h0, 5'd21);
      exp_q.push_back({1'b1, 5'd21, 64'd0});
      @(negedge clk);
      req_valid = 1'b0;
      check("t4_resp_at_n1", 70'(resp_valid), 70'd1);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (req_ready || mem_read || mem_write || !resp_valid) bad++;
         @(negedge clk);
      end
      check("t4_stall_no_ready_no_strobe", 70'(bad), 70'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      check("t4_retired", {68'd0, resp_valid, req_ready}, 70'd1);

      // ---- back-pressure with a second request held on req_valid ----
      resp_ready = 1'b0;
      drive(6'd58, 64'h13, 16'd0, 64'h0, 5'd22);
      exp_q.push_back({1'b0, 5'd22, 64'hDEADBEEF_01234567});
      @(negedge clk);
      drive(6'd34, 64'h10, 16'd3, 64'h0, 5'd23);
      exp_q.push_back({1'b0, 5'd23, 64'h67});
      seen = 1;
      bad  = 0;
      while (!resp_valid && seen <= TMO) begin
         if (req_ready) bad++;
         @(negedge clk);
         seen++;
      end
      check("t5_first_latency", 70'(seen), 70'(LAT + 1));
      d0 = resp_data;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!resp_valid || resp_data !== d0 || resp_rt !== 5'd22 || req_ready) bad++;
      end
      check("t5_stall_stable", 70'(bad), 70'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      check("t5_idle_gap", {68'd0, resp_valid, req_ready}, 70'd1);
      @(negedge clk);
      check("t5_second_accepted", {68'd0, req_ready, mem_read}, 70'd1);
      req_valid = 1'b0;
      seen = 0;
      while (!resp_valid && seen <= TMO) begin
         @(negedge clk);
         seen++;
      end
      check("t5_second_resp", 70'(resp_valid), 70'd1);
      @(negedge clk);

      // ---- reset in the middle of an access ----
      drive(6'd58, 64'h13, 16'd0, 64'h0, 5'd24);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("t6_strobe_before_reset", 70'(mem_read), 70'd1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_reset_drops_strobes",
            {65'd0, mem_read, mem_write, resp_valid, req_ready, 1'b0}, 70'h2);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (resp_valid) seen++;
         @(negedge clk);
      end
      check("t6_no_response", 70'(seen), 70'd0);
      check("t6_ready_after_reset", 70'(req_ready), 70'd1);
      do_req("t6_followup_ld", 6'd58, 64'h13, 16'd0, 64'h0, 5'd25, 64'hDEADBEEF_01234567, 1'b0);

      // ---- random mix against the reference memory ----
      for (int i = 0; i < 30; i++) begin
         op    = ops[$urandom_range(0, 9)];
         base  = 64'($urandom_range(0, 300));
         disp  = 16'($urandom_range(0, 40)) - 16'd20;
         sd    = {$urandom, $urandom};
         ea    = base + {{48{disp[15]}}, disp};
         legal = (is_ld(op) || is_st(op)) && (ea < 64'(DEPTH));
         do_req($sformatf("rnd%0d", i), op, base, disp, sd, 5'($urandom),
                (legal && is_ld(op)) ? fmt(ref_mem[ea[7:0]], op) : 64'd0, !legal);
      end

      // ---- final report ----
      repeat (2) @(negedge clk);
      check("no_strobe_overlap", 70'(overlap), 70'd0);
      check("exp_q_drained", 70'(exp_q.size()), 70'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
